// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch stage: ibus request/response,
// the fetch_data_t handed to decode, and the fetch FSM state encoding.
package fetch_queue_pkg;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
  } fetch_data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Sequential PC step; 64-bit unsigned, wraps silently.
  function automatic logic [63:0] next_pc(input logic [63:0] pc, input int unsigned step);
    return pc + 64'(step);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundles the ibus, redirect and decode handshake signals of the fetch stage.
// master = fetch_queue side, slave = the memory/decode/execute environment.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
);
  ibus_req_t                      ireq;
  ibus_resp_t                     iresp;
  logic                           redirect_valid;
  logic [63:0]                    redirect_pc;
  logic                           deq_valid;
  logic                           deq_ready;
  fetch_data_t                    deq_data;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (
    output ireq, deq_valid, deq_data, count,
    input  iresp, redirect_valid, redirect_pc, deq_ready
  );

  modport slave (
    input  ireq, deq_valid, deq_data, count,
    output iresp, redirect_valid, redirect_pc, deq_ready
  );

endinterface

// File: rtl/fetch_queue_chk.sv
// Simulation-only checks for the fetch FIFO; ignored by synthesis.
module fetch_queue_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  // The fetch FSM reserves a slot before issuing, so a push can never land on a full queue.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/fetch_queue_fifo.sv
// DEPTH x fetch_data_t FIFO with push/pop/flush; head is combinational and reads
// as zero when empty. Flush wins over a simultaneous push or pop.
module fetch_queue_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_data_t                push_data,
  output fetch_data_t                head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_data_t     mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push_s, do_pop_s, full_s;

  always_comb begin
    do_push_s = push & ~flush;
    do_pop_s  = pop & ~flush & (count_q != '0);
    full_s    = (count_q == CW'(DEPTH));
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      tail_d = do_push_s ? tail_q + PW'(1) : tail_q;
      head_d = do_pop_s  ? head_q + PW'(1) : head_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[tail_q] <= push_data;
    end
  end

  assign head  = (count_q != '0) ? mem_q[head_q] : '0;
  assign count = count_q;

  fetch_queue_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (do_push_s),
    .full  (full_s)
  );

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues one sequential ibus request at a time, buffers the
// returned instructions for decode, and handles redirects by flushing and draining.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [63:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          INSTR_BYTES = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t  state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  ibus_req_t     ireq_q, ireq_d;
  logic          push_s, pop_s, deq_valid_s;
  fetch_data_t   push_data_s, head_s;
  logic [CW-1:0] count_s, count_after_s;
  logic [63:0]   pc_plus_s;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    ireq_d        = ireq_q;
    push_s        = 1'b0;
    pc_plus_s     = next_pc(fetch_pc_q, INSTR_BYTES);
    push_data_s   = '{pc: fetch_pc_q, raw_instr: bus.iresp.data, valid: 1'b1};
    deq_valid_s   = (count_s != '0) & ~bus.redirect_valid;
    pop_s         = deq_valid_s & bus.deq_ready;
    count_after_s = count_s + CW'(1) - CW'(pop_s);
    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          fetch_pc_d = bus.redirect_pc;
        end else if (count_s < CW'(DEPTH)) begin
          state_d = REQ;
          ireq_d  = '{valid: 1'b1, addr: fetch_pc_q};
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.redirect_valid && bus.iresp.data_ok) begin
          // Response and redirect coincide: drop the data, nothing left to drain.
          fetch_pc_d = bus.redirect_pc;
          state_d    = IDLE;
          ireq_d     = '0;
        end else if (bus.redirect_valid) begin
          // Request stays on the bus with its old address until it completes.
          fetch_pc_d = bus.redirect_pc;
          state_d    = DRAIN;
        end else if (bus.iresp.data_ok) begin
          push_s     = 1'b1;
          fetch_pc_d = pc_plus_s;
          if (count_after_s < CW'(DEPTH)) begin
            state_d = REQ;
            ireq_d  = '{valid: 1'b1, addr: pc_plus_s};
          end else begin
            state_d = IDLE;
            ireq_d  = '0;
          end
        end else begin
          state_d = REQ;
        end
      end
      DRAIN: begin
        fetch_pc_d = bus.redirect_valid ? bus.redirect_pc : fetch_pc_q;
        if (bus.iresp.data_ok) begin
          state_d = IDLE;
          ireq_d  = '0;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        ireq_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      ireq_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ireq_q     <= ireq_d;
    end
  end

  fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .flush     (bus.redirect_valid),
    .push_data (push_data_s),
    .head      (head_s),
    .count     (count_s)
  );

  assign bus.ireq      = ireq_q;
  assign bus.deq_valid = deq_valid_s;
  assign bus.deq_data  = head_s;
  assign bus.count     = count_s;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage with a prefetch buffer. Issues sequential requests on the ibus and holds up to DEPTH fetched instructions in a FIFO.
- Hands instructions to decode through a valid/ready handshake, so an imem stall and a decode stall are decoupled.
- Supports redirect from execute/branch resolution: flushes the queue and squashes any request in flight.
- Sits between the ibus port and the decode pipeline register.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2)
- RESET_PC, 64'h8000_0000, first fetch address after reset
- INSTR_BYTES, 4, PC increment per sequential fetch

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ireq  out  ibus_req_t  instruction bus request (valid, addr)
- iresp  in  ibus_resp_t  instruction bus response (data_ok, data)
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch address
- deq_valid  out  1  head entry available to decode
- deq_ready  in  1  decode accepts head this cycle
- deq_data  out  fetch_data_t  {pc, raw_instr, valid=1} of head
- count  out  $clog2(DEPTH+1)  current occupancy (perf/debug)

Behaviour:
- Reset (async) clears the queue (count=0, head=tail=0), sets fetch_pc=RESET_PC and state=IDLE. While reset is high or immediately after reset: ireq.valid=0, deq_valid=0, deq_data='0.
- FSM states are IDLE, REQ and DRAIN.
  - IDLE -> REQ when count + inflight < DEPTH and no redirect. ireq.valid=1, ireq.addr=fetch_pc, registered.
  - REQ: hold ireq.valid and ireq.addr stable until iresp.data_ok. This is a bus rule; addr must never change under a pending valid.
  - REQ and data_ok: enqueue {fetch_pc, iresp.data}, then fetch_pc += INSTR_BYTES.
    - Go to REQ again the next cycle if a slot is still free after this enqueue and any dequeue. Otherwise go to IDLE.
    - One outstanding request at most.
  - REQ and redirect_valid without data_ok: go to DRAIN and set fetch_pc=redirect_pc. ireq stays valid on the old addr.
  - DRAIN: wait for data_ok. Discard the returned data. Go to IDLE, which issues redirect_pc the following cycle.
  - DRAIN and another redirect: overwrite fetch_pc and stay in DRAIN.
- Redirect in the same cycle as data_ok (REQ): discard the data, set fetch_pc=redirect_pc, go to IDLE. No drain is needed.
- Redirect in any state flushes the queue in that cycle (count=0). deq_valid is gated low in the redirect cycle, so decode never takes a squashed entry.
- Dequeue: deq_valid = (count!=0) & ~redirect_valid. On deq_valid & deq_ready the head pointer advances.
- Enqueue and dequeue in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Full condition: a request issues only if count<DEPTH (plus the in-flight slot), so an enqueue into a full queue cannot occur. Assert this in simulation.
- Empty: deq_data='0 and deq_valid=0. deq_data is combinational from the head entry; there is no extra latency.
- Latency: fetch_pc to deq_valid is 1 cycle after data_ok. The best-case sustained rate is one instruction per imem round trip + 1 cycle.
- All arithmetic on fetch_pc is 64-bit unsigned and wraps silently.

Decomposition:
- pipes package: fetch_data_t (existing) and a new fetch_state_t enum {IDLE, REQ, DRAIN}.
- common package: ibus_req_t/ibus_resp_t (existing), RESET_PC default constant.
- Sub-module: fetch_fifo, a parametrised DEPTH x fetch_data_t FIFO with push, pop, flush, count, head. It is reusable for a later decode buffer.
- The FSM and PC logic stay in fetch_queue.

Test Plan:
- Reset release, memory with 1-cycle data_ok, deq_ready=1 -> ireq.addr sequence 8000_0000, 8000_0004, 8000_0008…; deq_data.pc follows the same sequence; no gaps beyond 1 cycle per fetch.
- deq_ready=0 with DEPTH=4 -> exactly 4 enqueues, count=4, ireq.valid=0 thereafter. Raise deq_ready -> fetch resumes at 8000_0010 and deq order is preserved.
- Memory with 5-cycle latency, redirect to 8000_1000 on the 2nd wait cycle -> ireq.addr stays 8000_0000 until data_ok; that data is dropped; the next request addr is 8000_1000; the first deq pc is 8000_1000.
- Redirect in the same cycle as data_ok for 8000_0004 -> 8000_0004 is never dequeued; no DRAIN; the next ireq.addr is the redirect target one cycle later.
- Redirect while count=3 and deq_ready=1 -> deq_valid=0 in that cycle, count=0 next cycle, no stale pc ever seen by decode.
- Assert reset mid-REQ (asynchronously, between edges) -> ireq.valid and deq_valid drop immediately, count=0; after release the first ireq.addr is 8000_0000.
